// File: rtl/multicycle_ctrl_fsm.sv
// Multicycle MIPS control unit: Moore FSM whose selects and enables depend on the state only.
// Define CTRL_OVF_EXC_EN to trap ALU overflow on add/sub/addi into an overflow exception.
module multicycle_ctrl_fsm #(
    parameter int unsigned MEM_WAIT = 1,
    parameter int unsigned SEL_W    = 3,
    parameter int unsigned STATE_W  = 5
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [5:0]         op,
    input  logic [5:0]         funct,
    input  logic               overflow,
    output logic [SEL_W-1:0]   IorD,
    output logic               MemOp,
    output logic [SEL_W-1:0]   ALUSrcA,
    output logic [SEL_W-1:0]   ALUSrcB,
    output logic [SEL_W-1:0]   ALUOp,
    output logic [1:0]         PCSource,
    output logic               ExcSel,
    output logic               PCWrite,
    output logic               PCWriteCond,
    output logic               EPCWrite,
    output logic               IRWrite,
    output logic               AWrite,
    output logic               BWrite,
    output logic               ALUWrite,
    output logic               MDRWrite,
    output logic               RegWrite,
    output logic [2:0]         Cond,
    output logic [1:0]         RegDst,
    output logic [1:0]         MemToReg,
    output logic [STATE_W-1:0] state_o
);

    localparam int unsigned WAIT_W = 4;
    localparam int unsigned WaitLastInt = (MEM_WAIT > 0) ? MEM_WAIT - 1 : 0;
    localparam logic [WAIT_W-1:0] WaitLast = WAIT_W'(WaitLastInt);

    typedef enum logic [STATE_W-1:0] {
        StReset, StFetch, StFwait, StIrLoad, StDecode,
        StRExec, StRWb, StAddiExec, StIWb,
        StLwAddr, StLwMem, StLwWait, StLwMdr, StLwWb,
        StSwAddr, StSwMem, StBeq, StBne, StJump,
        StOpcExc, StOvfExc
    } state_e;

    state_e            state_q, state_d;
    logic [WAIT_W-1:0] cnt_q, cnt_d;
    logic [SEL_W-1:0]  alu_op_q, alu_op_d;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= StReset;
            cnt_q    <= '0;
            alu_op_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            alu_op_q <= alu_op_d;
        end
    end

`ifndef CTRL_OVF_EXC_EN
    logic unused_overflow;
    assign unused_overflow = overflow;
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        alu_op_d = alu_op_q;
        case (state_q)
            StReset:  state_d = StFetch;
            StFetch: begin
                cnt_d   = '0;
                state_d = (MEM_WAIT > 0) ? StFwait : StIrLoad;
            end
            StFwait: begin
                if (cnt_q == WaitLast) state_d = StIrLoad;
                else                   cnt_d   = cnt_q + WAIT_W'(1);
            end
            StIrLoad: state_d = StDecode;
            StDecode: begin
                case (op)
                    6'h00: begin
                        state_d = StRExec;
                        case (funct)
                            6'h20:   alu_op_d = SEL_W'(1);
                            6'h22:   alu_op_d = SEL_W'(2);
                            6'h24:   alu_op_d = SEL_W'(3);
                            default: state_d  = StOpcExc;
                        endcase
                    end
                    6'h08:   state_d = StAddiExec;
                    6'h23:   state_d = StLwAddr;
                    6'h2B:   state_d = StSwAddr;
                    6'h04:   state_d = StBeq;
                    6'h05:   state_d = StBne;
                    6'h02:   state_d = StJump;
                    default: state_d = StOpcExc;
                endcase
            end
            StRExec: begin
                state_d = StRWb;
`ifdef CTRL_OVF_EXC_EN
                // Logical and cannot overflow; only add/sub trap.
                if (overflow && alu_op_q != SEL_W'(3)) state_d = StOvfExc;
`endif
            end
            StAddiExec: begin
                state_d = StIWb;
`ifdef CTRL_OVF_EXC_EN
                if (overflow) state_d = StOvfExc;
`endif
            end
            StLwAddr: state_d = StLwMem;
            StLwMem: begin
                cnt_d   = '0;
                state_d = (MEM_WAIT > 0) ? StLwWait : StLwMdr;
            end
            StLwWait: begin
                if (cnt_q == WaitLast) state_d = StLwMdr;
                else                   cnt_d   = cnt_q + WAIT_W'(1);
            end
            StLwMdr:  state_d = StLwWb;
            StSwAddr: state_d = StSwMem;
            StRWb, StIWb, StLwWb, StSwMem, StBeq, StBne, StJump, StOpcExc, StOvfExc:
                state_d = StFetch;
            default:  state_d = StReset;
        endcase
    end

    // Outputs are forced low while reset is held, even though the state already reads RESET.
    always_comb begin
        IorD        = '0;
        MemOp       = 1'b0;
        ALUSrcA     = '0;
        ALUSrcB     = '0;
        ALUOp       = '0;
        PCSource    = 2'd0;
        ExcSel      = 1'b0;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        EPCWrite    = 1'b0;
        IRWrite     = 1'b0;
        AWrite      = 1'b0;
        BWrite      = 1'b0;
        ALUWrite    = 1'b0;
        MDRWrite    = 1'b0;
        RegWrite    = 1'b0;
        Cond        = 3'd0;
        RegDst      = 2'd0;
        MemToReg    = 2'd0;
        if (reset) begin
            case (state_q)
                StReset: begin
                    RegWrite = 1'b1;
                    RegDst   = 2'd2;
                    MemToReg = 2'd2;
                end
                StFetch: begin
                    ALUSrcB = SEL_W'(1);
                    ALUOp   = SEL_W'(1);
                    PCWrite = 1'b1;
                end
                StIrLoad: IRWrite = 1'b1;
                StDecode: begin
                    AWrite   = 1'b1;
                    BWrite   = 1'b1;
                    ALUWrite = 1'b1;
                    ALUSrcB  = SEL_W'(3);
                    ALUOp    = SEL_W'(1);
                end
                StRExec: begin
                    ALUSrcA  = SEL_W'(1);
                    ALUOp    = alu_op_q;
                    ALUWrite = 1'b1;
                end
                StRWb: begin
                    RegWrite = 1'b1;
                    RegDst   = 2'd1;
                end
                StAddiExec, StLwAddr, StSwAddr: begin
                    ALUSrcA  = SEL_W'(1);
                    ALUSrcB  = SEL_W'(2);
                    ALUOp    = SEL_W'(1);
                    ALUWrite = 1'b1;
                end
                StIWb:   RegWrite = 1'b1;
                StLwMem: IorD     = SEL_W'(1);
                StLwMdr: MDRWrite = 1'b1;
                StLwWb: begin
                    RegWrite = 1'b1;
                    MemToReg = 2'd1;
                end
                StSwMem: begin
                    IorD  = SEL_W'(1);
                    MemOp = 1'b1;
                end
                StBeq, StBne: begin
                    ALUSrcA     = SEL_W'(1);
                    ALUOp       = SEL_W'(2);
                    PCWriteCond = 1'b1;
                    PCSource    = 2'd1;
                    Cond        = (state_q == StBeq) ? 3'd1 : 3'd2;
                end
                StJump: begin
                    PCWrite  = 1'b1;
                    PCSource = 2'd2;
                end
                StOpcExc, StOvfExc: begin
                    EPCWrite = 1'b1;
                    PCWrite  = 1'b1;
                    PCSource = 2'd3;
                    ExcSel   = (state_q == StOvfExc);
                end
                default: ;
            endcase
        end
    end

    assign state_o = state_q;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Bench for multicycle_ctrl_fsm: two instances (MEM_WAIT=1 and 2) checked cycle by cycle
// against an instruction-level model of the expected control words.
module tb_multicycle_ctrl_fsm;

    typedef struct packed {
        logic [2:0] iord;
        logic       memop;
        logic [2:0] alusrca;
        logic [2:0] alusrcb;
        logic [2:0] aluop;
        logic [1:0] pcsource;
        logic       excsel;
        logic       pcwrite;
        logic       pcwritecond;
        logic       epcwrite;
        logic       irwrite;
        logic       awrite;
        logic       bwrite;
        logic       aluwrite;
        logic       mdrwrite;
        logic       regwrite;
        logic [2:0] cond;
        logic [1:0] regdst;
        logic [1:0] memtoreg;
    } ctrl_t;

`ifdef CTRL_OVF_EXC_EN
    localparam bit OvfEn = 1'b1;
`else
    localparam bit OvfEn = 1'b0;
`endif

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic       rst_v [2];
    logic [5:0] op_v  [2];
    logic [5:0] fn_v  [2];
    logic       ov_v  [2];
    ctrl_t      act   [2];
    logic [4:0] unused_state [2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        multicycle_ctrl_fsm #(.MEM_WAIT(g + 1), .SEL_W(3), .STATE_W(5)) u_dut (
            .clock       (clock),
            .reset       (rst_v[g]),
            .op          (op_v[g]),
            .funct       (fn_v[g]),
            .overflow    (ov_v[g]),
            .IorD        (act[g].iord),
            .MemOp       (act[g].memop),
            .ALUSrcA     (act[g].alusrca),
            .ALUSrcB     (act[g].alusrcb),
            .ALUOp       (act[g].aluop),
            .PCSource    (act[g].pcsource),
            .ExcSel      (act[g].excsel),
            .PCWrite     (act[g].pcwrite),
            .PCWriteCond (act[g].pcwritecond),
            .EPCWrite    (act[g].epcwrite),
            .IRWrite     (act[g].irwrite),
            .AWrite      (act[g].awrite),
            .BWrite      (act[g].bwrite),
            .ALUWrite    (act[g].aluwrite),
            .MDRWrite    (act[g].mdrwrite),
            .RegWrite    (act[g].regwrite),
            .Cond        (act[g].cond),
            .RegDst      (act[g].regdst),
            .MemToReg    (act[g].memtoreg),
            .state_o     (unused_state[g])
        );
    end

    int checks = 0;
    int errors = 0;
    int lat_cnt [2];

    ctrl_t exp_q[$];
    string tag_q[$];
    int    inst_q[$];
    ctrl_t seq_q[$];
    string seqtag_q[$];

    function automatic void check(string name, int unsigned a, int unsigned e);
        checks++;
        if (a != e) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, a, e);
        end
    endfunction

    // Cycles since the last FETCH word (inclusive) for each instance.
    always @(negedge clock) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst_v[k])
                lat_cnt[k] <= 0;
            else if (act[k].pcwrite && act[k].alusrcb == 3'd1 && act[k].aluop == 3'd1)
                lat_cnt[k] <= 1;
            else
                lat_cnt[k] <= lat_cnt[k] + 1;
        end
    end

    // Single compare process: one expected word per cycle, popped at the falling edge.
    always @(negedge clock) begin
        ctrl_t e;
        string t;
        int    k;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            k = inst_q.pop_front();
            check($sformatf("dut%0d_%s", k, t), act[k], e);
        end
    end

    function automatic void add(ctrl_t c, string t);
        seq_q.push_back(c);
        seqtag_q.push_back(t);
    endfunction

    function automatic void add_exc(logic e);
        ctrl_t c = '0;
        c.epcwrite = 1'b1;
        c.pcwrite  = 1'b1;
        c.pcsource = 2'd3;
        c.excsel   = e;
        add(c, e ? "ovf_exc" : "opc_exc");
    endfunction

    function automatic void add_addr(string t);
        ctrl_t c = '0;
        c.alusrca  = 3'd1;
        c.alusrcb  = 3'd2;
        c.aluop    = 3'd1;
        c.aluwrite = 1'b1;
        add(c, t);
    endfunction

    // Expected control-word sequence for one instruction, FETCH up to the cycle before next FETCH.
    function automatic void build(int m, logic [5:0] o, logic [5:0] f, logic ov);
        ctrl_t c;
        int    k;
        seq_q.delete();
        seqtag_q.delete();
        c = '0; c.pcwrite = 1'b1; c.alusrcb = 3'd1; c.aluop = 3'd1; add(c, "fetch");
        for (int i = 0; i < m; i++) add('0, "fwait");
        c = '0; c.irwrite = 1'b1; add(c, "irload");
        c = '0; c.awrite = 1'b1; c.bwrite = 1'b1; c.aluwrite = 1'b1;
        c.alusrcb = 3'd3; c.aluop = 3'd1; add(c, "decode");
        case (o)
            6'h00: begin
                k = (f == 6'h20) ? 1 : (f == 6'h22) ? 2 : (f == 6'h24) ? 3 : 0;
                if (k == 0) add_exc(1'b0);
                else begin
                    c = '0; c.alusrca = 3'd1; c.aluwrite = 1'b1; c.aluop = 3'(k);
                    add(c, "r_exec");
                    if (OvfEn && ov && k != 3) add_exc(1'b1);
                    else begin
                        c = '0; c.regwrite = 1'b1; c.regdst = 2'd1; add(c, "r_wb");
                    end
                end
            end
            6'h08: begin
                add_addr("addi_exec");
                if (OvfEn && ov) add_exc(1'b1);
                else begin
                    c = '0; c.regwrite = 1'b1; add(c, "i_wb");
                end
            end
            6'h23: begin
                add_addr("lw_addr");
                c = '0; c.iord = 3'd1; add(c, "lw_mem");
                for (int i = 0; i < m; i++) add('0, "lw_wait");
                c = '0; c.mdrwrite = 1'b1; add(c, "lw_mdr");
                c = '0; c.regwrite = 1'b1; c.memtoreg = 2'd1; add(c, "lw_wb");
            end
            6'h2B: begin
                add_addr("sw_addr");
                c = '0; c.iord = 3'd1; c.memop = 1'b1; add(c, "sw_mem");
            end
            6'h04, 6'h05: begin
                c = '0; c.alusrca = 3'd1; c.aluop = 3'd2; c.pcwritecond = 1'b1;
                c.pcsource = 2'd1; c.cond = (o == 6'h04) ? 3'd1 : 3'd2;
                add(c, "branch");
            end
            6'h02: begin
                c = '0; c.pcwrite = 1'b1; c.pcsource = 2'd2; add(c, "jump");
            end
            default: add_exc(1'b0);
        endcase
    endfunction

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic push(int k, ctrl_t c, string t);
        exp_q.push_back(c);
        tag_q.push_back(t);
        inst_q.push_back(k);
    endtask

    // Assert reset in the current cycle, hold n cycles, then expect the RESET word.
    task automatic reset_phase(int k, int n);
        ctrl_t c = '0;
        rst_v[k] = 1'b0;
        push(k, '0, "reset_held");
        for (int i = 1; i < n; i++) begin
            next_cycle();
            push(k, '0, "reset_held");
        end
        next_cycle();
        rst_v[k] = 1'b1;
        c.regwrite = 1'b1; c.regdst = 2'd2; c.memtoreg = 2'd2;
        push(k, c, "reset_state");
    endtask

    task automatic start_instr(int k, logic [5:0] o, logic [5:0] f, logic ov, int n);
        build(k + 1, o, f, ov);
        for (int i = 0; i < n; i++) begin
            next_cycle();
            if (i == 0) begin
                op_v[k] = o;
                fn_v[k] = f;
                ov_v[k] = ov;
            end
            push(k, seq_q[i], seqtag_q[i]);
        end
    endtask

    task automatic run_instr(int k, logic [5:0] o, logic [5:0] f, logic ov, int lat1, int lat2);
        build(k + 1, o, f, ov);
        start_instr(k, o, f, ov, seq_q.size());
        @(negedge clock);
        #1;
        check($sformatf("dut%0d_latency_op%0h_fn%0h", k, o, f), lat_cnt[k], (k == 0) ? lat1 : lat2);
    endtask

    task automatic run_suite(int k);
        reset_phase(k, 3);
        run_instr(k, 6'h00, 6'h20, 1'b0, 6, 7);
        run_instr(k, 6'h00, 6'h22, 1'b0, 6, 7);
        run_instr(k, 6'h00, 6'h24, 1'b1, 6, 7);
        run_instr(k, 6'h00, 6'h20, 1'b1, 6, 7);
        run_instr(k, 6'h08, 6'h00, 1'b0, 6, 7);
        run_instr(k, 6'h08, 6'h00, 1'b1, 6, 7);
        run_instr(k, 6'h23, 6'h00, 1'b0, 9, 11);
        run_instr(k, 6'h2B, 6'h00, 1'b0, 6, 7);
        run_instr(k, 6'h04, 6'h00, 1'b0, 5, 6);
        run_instr(k, 6'h05, 6'h00, 1'b0, 5, 6);
        run_instr(k, 6'h02, 6'h00, 1'b0, 5, 6);
        run_instr(k, 6'h3F, 6'h00, 1'b0, 5, 6);
        run_instr(k, 6'h00, 6'h01, 1'b0, 5, 6);
        // lw aborted by reset in LW_MEM: up to LW_ADDR, then reset in the next cycle.
        start_instr(k, 6'h23, 6'h00, 1'b0, k + 1 + 4);
        next_cycle();
        reset_phase(k, 2);
        run_instr(k, 6'h08, 6'h00, 1'b0, 6, 7);
        build(k + 1, 6'h00, 6'h20, 1'b0);
        next_cycle();
        push(k, seq_q[0], "final_fetch");
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            rst_v[k] = 1'b0;
            op_v[k]  = 6'h00;
            fn_v[k]  = 6'h00;
            ov_v[k]  = 1'b0;
        end
        next_cycle();
        run_suite(0);
        next_cycle();
        rst_v[0] = 1'b0;
        run_suite(1);
        @(negedge clock);
        #1;
        check("expect_queue_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
